// File: rtl/event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : event_scheduler
// Purpose  : FIFO of timestamped events that drives per-channel value strobes
//            when each head event's time arrives. Optional macro:
//            EVENT_SCHEDULER_HOLD_EN (input_data holds last dispatched value).
// Revision : 1.0
// ============================================================================
module event_scheduler #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 64,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  logic [TS_W-1:0]          ev_ts,
    input  logic [NUM_CH-1:0]        ev_mask,
    input  logic [NUM_CH*DATA_W-1:0] ev_data,
    output logic [NUM_CH*DATA_W-1:0] input_data,
    output logic [NUM_CH-1:0]        new_input,
    output logic                     late,
    output logic [TS_W-1:0]          time_now,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [TS_W-1:0]          ts_mem   [DEPTH];
    logic [NUM_CH-1:0]        mask_mem [DEPTH];
    logic [NUM_CH*DATA_W-1:0] data_mem [DEPTH];

    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [TS_W-1:0]          head_ts;
    logic [NUM_CH-1:0]        head_mask;
    logic [NUM_CH*DATA_W-1:0] head_data;
    logic signed [TS_W-1:0]   head_diff;
    logic                     head_due;
    logic                     push;
    logic                     pop;

    assign head_ts   = ts_mem[rd_ptr];
    assign head_mask = mask_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Modular difference keeps the due test correct across time_now wrap.
    assign head_diff = head_ts - time_now;
    assign head_due  = head_diff[TS_W-1] || (head_diff == '0);

    assign ev_ready = rst && (count < FULL_CNT);
    assign push     = ev_valid && ev_ready;
    // count excludes this edge's push, so a fresh entry waits one cycle.
    assign pop      = en && (count != '0) && head_due;

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr]   <= ev_ts;
            mask_mem[wr_ptr] <= ev_mask;
            data_mem[wr_ptr] <= ev_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            time_now <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (en)
                time_now <= time_now + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            new_input  <= '0;
            late       <= 1'b0;
            input_data <= '0;
        end else begin
            new_input <= pop ? head_mask : '0;
            late      <= pop && (head_mask != '0) && head_diff[TS_W-1];
            for (int k = 0; k < NUM_CH; k++) begin
                if (pop && head_mask[k])
                    input_data[k*DATA_W +: DATA_W] <= head_data[k*DATA_W +: DATA_W];
`ifndef EVENT_SCHEDULER_HOLD_EN
                else
                    input_data[k*DATA_W +: DATA_W] <= '0;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_scheduler
// Purpose  : Self-checking bench for event_scheduler with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_event_scheduler;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 64;
    localparam int TS_W   = 32;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     en = 1'b0;
    logic                     ev_valid = 1'b0;
    logic                     ev_ready;
    logic [TS_W-1:0]          ev_ts = '0;
    logic [NUM_CH-1:0]        ev_mask = '0;
    logic [NUM_CH*DATA_W-1:0] ev_data = '0;
    logic [NUM_CH*DATA_W-1:0] input_data;
    logic [NUM_CH-1:0]        new_input;
    logic                     late;
    logic [TS_W-1:0]          time_now;
    logic [CW-1:0]            count;

    logic                     rst8 = 1'b0;
    logic                     en8 = 1'b0;
    logic                     v8 = 1'b0;
    logic                     rdy8;
    logic [7:0]               ts8 = '0;
    logic [NUM_CH-1:0]        mask8 = '0;
    logic [NUM_CH*DATA_W-1:0] data8 = '0;
    logic [NUM_CH*DATA_W-1:0] idata8;
    logic [NUM_CH-1:0]        new8;
    logic                     late8;
    logic [7:0]               time8;
    logic [2:0]               count8;

    int checks = 0;
    int errors = 0;

    event_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_ts(ev_ts), .ev_mask(ev_mask), .ev_data(ev_data), .input_data(input_data),
        .new_input(new_input), .late(late), .time_now(time_now), .count(count)
    );

    event_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(8), .DEPTH(4)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .ev_valid(v8), .ev_ready(rdy8),
        .ev_ts(ts8), .ev_mask(mask8), .ev_data(data8), .input_data(idata8),
        .new_input(new8), .late(late8), .time_now(time8), .count(count8)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of pending events plus a cycle counter.
    typedef struct {
        logic [TS_W-1:0]          ts;
        logic [NUM_CH-1:0]        mask;
        logic [NUM_CH*DATA_W-1:0] data;
    } ev_t;

    ev_t                      q[$];
    logic [TS_W-1:0]          m_time = '0;
    logic [NUM_CH-1:0]        m_new = '0;
    logic [NUM_CH*DATA_W-1:0] m_data = '0;
    logic                     m_late = 1'b0;

    task automatic clear_model();
        q.delete();
        m_time = '0;
        m_new  = '0;
        m_data = '0;
        m_late = 1'b0;
    endtask

    task automatic tick();
        bit do_push;
        bit do_pop;
        logic signed [TS_W-1:0] d;
        ev_t e;
        d = '0;
        do_push = rst && ev_valid && (q.size() < DEPTH);
        do_pop  = 1'b0;
        if (rst && en && q.size() > 0) begin
            d = q[0].ts - m_time;
            do_pop = (d <= 0);
        end
        @(posedge clk);
        if (!rst) begin
            clear_model();
        end else begin
            m_new  = '0;
            m_late = 1'b0;
`ifndef EVENT_SCHEDULER_HOLD_EN
            m_data = '0;
`endif
            if (do_pop) begin
                e = q.pop_front();
                m_new  = e.mask;
                m_late = (e.mask != '0) && (d < 0);
                for (int k = 0; k < NUM_CH; k++)
                    if (e.mask[k])
                        m_data[k*DATA_W +: DATA_W] = e.data[k*DATA_W +: DATA_W];
            end
            if (do_push) begin
                e.ts   = ev_ts;
                e.mask = ev_mask;
                e.data = ev_data;
                q.push_back(e);
            end
            if (en)
                m_time = m_time + 1;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        en = 1'b0;
        ev_valid = 1'b0;
        #1;
        clear_model();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (time_now !== '0) begin errors++; $display("FAIL reset_time: got %0d want 0", time_now); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (new_input !== '0 || late !== 1'b0) begin errors++; $display("FAIL reset_strobe: new %b late %b want 0", new_input, late); end
        checks++; if (input_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", input_data); end
        checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", ev_ready); end
        rst = 1'b1;
        #1;
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %b want 1", ev_ready); end
    endtask

    task automatic test_basic();
        int strobes;
        logic [NUM_CH*DATA_W-1:0] exp_d;
        apply_reset();
        en = 1'b1;
        ev_valid = 1'b1; ev_ts = 500; ev_mask = 2'b11; ev_data = {64'd1, 64'd1};
        tick();
        ev_valid = 1'b0;
        strobes = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (new_input !== '0) begin
                strobes++;
                checks++; if (time_now !== 501) begin errors++; $display("FAIL basic_time: got %0d want 501", time_now); end
                checks++; if (new_input !== 2'b11 || late !== 1'b0) begin errors++; $display("FAIL basic_strobe: new %b late %b want 11/0", new_input, late); end
                checks++; if (input_data !== {64'd1, 64'd1}) begin errors++; $display("FAIL basic_data: got %h", input_data); end
            end else begin
`ifdef EVENT_SCHEDULER_HOLD_EN
                exp_d = (time_now > 501) ? {64'd1, 64'd1} : '0;
`else
                exp_d = '0;
`endif
                checks++; if (input_data !== exp_d) begin errors++; $display("FAIL basic_idle_data: got %h want %h", input_data, exp_d); end
            end
        end
        checks++; if (strobes != 1) begin errors++; $display("FAIL basic_strobe_count: got %0d want 1", strobes); end
    endtask

    task automatic test_two_events();
        logic [NUM_CH-1:0] exp_n;
        logic [DATA_W-1:0] exp0, exp1;
        apply_reset();
        en = 1'b1;
        ev_valid = 1'b1; ev_ts = 1000; ev_mask = 2'b01; ev_data = {64'd0, 64'd2};
        tick();
        ev_ts = 1500; ev_mask = 2'b10; ev_data = {64'd4, 64'd0};
        tick();
        ev_valid = 1'b0;
        for (int i = 0; i < 1600; i++) begin
            tick();
            exp_n = (time_now == 1001) ? 2'b01 : (time_now == 1501) ? 2'b10 : 2'b00;
`ifdef EVENT_SCHEDULER_HOLD_EN
            exp0 = (time_now >= 1001) ? 64'd2 : 64'd0;
            exp1 = (time_now >= 1501) ? 64'd4 : 64'd0;
`else
            exp0 = (time_now == 1001) ? 64'd2 : 64'd0;
            exp1 = (time_now == 1501) ? 64'd4 : 64'd0;
`endif
            checks++; if (new_input !== exp_n || late !== 1'b0) begin errors++; $display("FAIL two_strobe t=%0d: new %b late %b want %b/0", time_now, new_input, late, exp_n); end
            checks++; if (input_data !== {exp1, exp0}) begin errors++; $display("FAIL two_data t=%0d: got %h want %h", time_now, input_data, {exp1, exp0}); end
        end
    endtask

    task automatic test_full();
        int strobes;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            ev_valid = 1'b1; ev_ts = 5; ev_mask = 2'b11;
            ev_data = {DATA_W'(i + 100), DATA_W'(i)};
            #1;
            checks++; if (ev_ready !== (i < 16)) begin errors++; $display("FAIL full_ready i=%0d: got %b want %b", i, ev_ready, (i < 16)); end
            tick();
            checks++; if (new_input !== '0) begin errors++; $display("FAIL full_no_dispatch_en0: got %b want 0", new_input); end
        end
        ev_valid = 1'b0;
        checks++; if (count !== 16) begin errors++; $display("FAIL full_count: got %0d want 16", count); end
        checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL full_ready_final: got %b want 0", ev_ready); end
        en = 1'b1;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (new_input !== '0) strobes++;
            checks++; if (new_input !== m_new || late !== m_late) begin errors++; $display("FAIL full_strobe: new %b late %b want %b/%b", new_input, late, m_new, m_late); end
            checks++; if (input_data !== m_data) begin errors++; $display("FAIL full_data: got %h want %h", input_data, m_data); end
            checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL full_drain_count: got %0d want %0d", count, q.size()); end
        end
        checks++; if (strobes != 16) begin errors++; $display("FAIL full_strobe_total: got %0d want 16", strobes); end
    endtask

    task automatic test_late();
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 200; i++) tick();
        checks++; if (time_now !== 200) begin errors++; $display("FAIL late_time: got %0d want 200", time_now); end
        ev_valid = 1'b1; ev_ts = 100; ev_mask = 2'b10; ev_data = {64'd99, 64'd0};
        tick();
        ev_valid = 1'b0;
        checks++; if (new_input !== '0) begin errors++; $display("FAIL late_early_strobe: got %b want 0", new_input); end
        tick();
        checks++; if (new_input !== 2'b10 || late !== 1'b1) begin errors++; $display("FAIL late_strobe: new %b late %b want 10/1", new_input, late); end
        checks++; if (input_data[2*DATA_W-1:DATA_W] !== 64'd99) begin errors++; $display("FAIL late_data: got %0d want 99", input_data[2*DATA_W-1:DATA_W]); end
        tick();
        checks++; if (new_input !== '0 || late !== 1'b0) begin errors++; $display("FAIL late_one_cycle: new %b late %b want 0", new_input, late); end
    endtask

    task automatic test_wrap();
        int strobes;
        en = 1'b0;
        rst8 = 1'b1;
        en8 = 1'b1;
        for (int i = 0; i < 250; i++) tick();
        checks++; if (time8 !== 8'd250) begin errors++; $display("FAIL wrap_time: got %0d want 250", time8); end
        checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b want 1", rdy8); end
        v8 = 1'b1; ts8 = 8'd4; mask8 = 2'b11; data8 = {64'd7, 64'd9};
        tick();
        v8 = 1'b0;
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (new8 !== '0) begin
                strobes++;
                checks++; if (time8 !== 8'd5) begin errors++; $display("FAIL wrap_strobe_time: got %0d want 5", time8); end
                checks++; if (new8 !== 2'b11 || late8 !== 1'b0) begin errors++; $display("FAIL wrap_strobe: new %b late %b want 11/0", new8, late8); end
                checks++; if (idata8 !== {64'd7, 64'd9}) begin errors++; $display("FAIL wrap_data: got %h", idata8); end
            end
        end
        checks++; if (strobes != 1) begin errors++; $display("FAIL wrap_strobe_count: got %0d want 1", strobes); end
        checks++; if (count8 !== 3'd0) begin errors++; $display("FAIL wrap_count: got %0d want 0", count8); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ev_valid = 1'b1; ev_ts = 4; ev_mask = 2'b11;
            ev_data = {DATA_W'(i + 1), DATA_W'(i + 11)};
            tick();
        end
        ev_valid = 1'b0;
        tick();
        tick();
        checks++; if (new_input !== m_new || new_input === '0) begin errors++; $display("FAIL mid_pre_strobe: got %b want %b", new_input, m_new); end
        checks++; if (count !== 2) begin errors++; $display("FAIL mid_pre_count: got %0d want 2", count); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (time_now !== '0 || count !== '0) begin errors++; $display("FAIL mid_clear: time %0d count %0d want 0", time_now, count); end
        checks++; if (new_input !== '0 || late !== 1'b0 || input_data !== '0) begin errors++; $display("FAIL mid_outputs: new %b late %b data %h want 0", new_input, late, input_data); end
        checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", ev_ready); end
        clear_model();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++; if (new_input !== '0 || count !== '0) begin errors++; $display("FAIL mid_after_release: new %b count %0d want 0", new_input, count); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            ev_valid = $urandom_range(0, 1);
            ev_ts    = m_time + TS_W'($urandom_range(0, 24)) - TS_W'(6);
            ev_mask  = NUM_CH'($urandom_range(0, 3));
            ev_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checks++; if (ev_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready: got %b want %b", ev_ready, (q.size() < DEPTH)); end
            tick();
            checks++; if (new_input !== m_new || late !== m_late) begin errors++; $display("FAIL rnd_strobe: new %b late %b want %b/%b", new_input, late, m_new, m_late); end
            checks++; if (input_data !== m_data) begin errors++; $display("FAIL rnd_data: got %h want %h", input_data, m_data); end
            checks++; if (count !== CW'(q.size()) || time_now !== m_time) begin errors++; $display("FAIL rnd_state: count %0d time %0d want %0d/%0d", count, time_now, q.size(), m_time); end
        end
        ev_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_events();
        test_full();
        test_late();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_scheduler.md
EVENT_SCHEDULER -- requirements
Module: event_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of monitor input channels driven.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the signed width of each channel value.
REQ-003 SHALL have parameter TS_W, default 32, meaning the timestamp and time-counter width in clock cycles.
REQ-004 SHALL have parameter DEPTH, default 16, meaning the event FIFO depth, a power of two and at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: time-advance and dispatch enable.
REQ-008 SHALL have ports ev_valid (input, 1) and ev_ready (output, 1): event push handshake.
REQ-009 SHALL have port ev_ts, input, TS_W bits: absolute dispatch time of the pushed event.
REQ-010 SHALL have port ev_mask, input, NUM_CH bits: which channels carry a new value.
REQ-011 SHALL have port ev_data, input, NUM_CH*DATA_W bits: channel values, channel k in bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port input_data, output, NUM_CH*DATA_W bits: values presented to the monitor.
REQ-013 SHALL have port new_input, output, NUM_CH bits: per-channel one-cycle value strobes.
REQ-014 SHALL have ports late (output, 1), time_now (output, TS_W) and count (output, log2(DEPTH)+1).

Function
REQ-015 SHALL accept an event on a rising edge with ev_valid=1 and ev_ready=1, and SHALL drive ev_ready = (count < DEPTH), independent of a same-cycle pop.
REQ-016 SHALL increment time_now by 1 on each rising edge with en=1, wrap from 2^TS_W-1 to 0, and hold it when en=0.
REQ-017 SHALL treat the head event as due when the TS_W-bit signed difference (ev_ts - time_now) is <= 0, so comparison is wrap-safe for distances below 2^(TS_W-1).
REQ-018 SHALL pop the due head on a rising edge with en=1 and count>0, and on that edge register new_input = head mask and input_data = head data for masked channels; latency from time_now==ev_ts to the strobe is 1 cycle.
REQ-019 SHALL hold every new_input bit high for exactly one cycle per dispatch and pop at most one event per cycle.
REQ-020 SHALL register late=1 alongside the strobe when the difference in REQ-017 is < 0, otherwise 0.
REQ-021 SHALL make a pushed event eligible for dispatch no earlier than the cycle after it is written, including on an empty FIFO.
REQ-022 SHALL dispatch strictly in FIFO order; a non-due head blocks later entries regardless of their timestamps.
REQ-023 SHALL pop an event with ev_mask=0 with no strobe, and SHALL leave late=0 for that event.
REQ-024 SHALL update count by +1 on push-only, -1 on pop-only and 0 on simultaneous push and pop, never exceeding DEPTH.
REQ-025 SHALL accept pushes while en=0, but SHALL NOT dispatch while en=0.

Reset
REQ-026 SHALL on rst=0 immediately clear time_now, count, new_input, late, input_data and the FIFO pointers to 0, and drive ev_ready=0 while reset is asserted.
REQ-027 SHALL discard queued events on reset mid-operation, with no strobe emitted on the first edge after release.

Configuration
REQ-028 SHALL honour the macro EVENT_SCHEDULER_HOLD_EN: when defined, each channel of input_data holds its last dispatched value between strobes; when undefined, input_data is 0 on every cycle where that channel's new_input is 0.

Verification
REQ-029 SHALL check: after reset, en=1, push ts=500, mask=2'b11, data={1,1} -> new_input=2'b11 and input_data={1,1} for exactly one cycle when time_now=501, late=0.
REQ-030 SHALL check: push ts=1000 mask=01 data0=2, then ts=1500 mask=10 data1=4 -> single strobes at time_now 1001 and 1501; between strobes input_data is 0 without the macro and holds the values with it.
REQ-031 SHALL check: with DEPTH=16, push 17 events with en=0 -> ev_ready=0 after the 16th and count=16; after raising en, entries drain one per cycle once due.
REQ-032 SHALL check: with time_now=200, push ts=100 -> dispatch on the next eligible edge with late=1.
REQ-033 SHALL check: with TS_W=8 and time_now=250, push ts=4 -> strobe when time_now=5 after the wrap, late=0.
REQ-034 SHALL check: with 3 events queued, assert rst=0 mid-run -> all outputs are 0 immediately, count=0, and no strobes occur after release until new pushes arrive.
